// File: rtl/triangle_scan_controller_pkg.sv
// rtl/triangle_scan_controller_pkg.sv - shared types and Q16.16 fixed-point helpers
package triangle_scan_controller_pkg;

    localparam int FP_FRAC_BITS = 16;
    localparam int FP_CEIL_BIAS = (1 << FP_FRAC_BITS) - 1;

    typedef logic signed [31:0] fixed_point_t;

    typedef struct packed {
        fixed_point_t x;
        fixed_point_t y;
        fixed_point_t z;
        fixed_point_t w;
    } vector4_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCAN,
        ST_DRAIN
    } scan_state_t;

    // Smallest integer >= v; widened by one bit so the bias cannot overflow.
    function automatic fixed_point_t fp_ceil(input fixed_point_t v);
        return fixed_point_t'((33'(v) + 33'(FP_CEIL_BIAS)) >>> FP_FRAC_BITS);
    endfunction

    // Largest integer <= v.
    function automatic fixed_point_t fp_floor(input fixed_point_t v);
        return v >>> FP_FRAC_BITS;
    endfunction

    function automatic fixed_point_t min3(input fixed_point_t a, b, c);
        fixed_point_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic fixed_point_t max3(input fixed_point_t a, b, c);
        fixed_point_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/triangle_scan_controller_if.sv
// rtl/triangle_scan_controller_if.sv - triangle input, rasterizer and pixel output bundle
interface triangle_scan_controller_if;
    import triangle_scan_controller_pkg::*;

    logic         i_start;
    vector4_t     i_v1, i_v2, i_v3;
    vector4_t     i_c1, i_c2, i_c3;
    logic         o_busy;
    logic         o_done;
    vector4_t     o_v1, o_v2, o_v3;
    vector4_t     o_c1, o_c2, o_c3;
    fixed_point_t o_x, o_y;
    logic         i_raster_write;
    vector4_t     i_raster_colour;
    logic         o_pixel_valid;
    logic         i_pixel_ready;
    fixed_point_t o_pixel_x, o_pixel_y;
    vector4_t     o_pixel_colour;

    modport slave (
        input  i_start, i_v1, i_v2, i_v3, i_c1, i_c2, i_c3,
        input  i_raster_write, i_raster_colour, i_pixel_ready,
        output o_busy, o_done, o_v1, o_v2, o_v3, o_c1, o_c2, o_c3,
        output o_x, o_y, o_pixel_valid, o_pixel_x, o_pixel_y, o_pixel_colour
    );

    modport master (
        output i_start, i_v1, i_v2, i_v3, i_c1, i_c2, i_c3,
        output i_raster_write, i_raster_colour, i_pixel_ready,
        input  o_busy, o_done, o_v1, o_v2, o_v3, o_c1, o_c2, o_c3,
        input  o_x, o_y, o_pixel_valid, o_pixel_x, o_pixel_y, o_pixel_colour
    );

endinterface

// File: rtl/triangle_bounding_box.sv
// rtl/triangle_bounding_box.sv - combinational integer pixel bounds of a triangle, clamped to screen
module triangle_bounding_box
    import triangle_scan_controller_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  fixed_point_t x1,
    input  fixed_point_t y1,
    input  fixed_point_t x2,
    input  fixed_point_t y2,
    input  fixed_point_t x3,
    input  fixed_point_t y3,
    output fixed_point_t xmin,
    output fixed_point_t xmax,
    output fixed_point_t ymin,
    output fixed_point_t ymax,
    output logic         empty
);

    localparam fixed_point_t X_LAST = fixed_point_t'(SCREEN_WIDTH - 1);
    localparam fixed_point_t Y_LAST = fixed_point_t'(SCREEN_HEIGHT - 1);

    fixed_point_t raw_xmin, raw_xmax, raw_ymin, raw_ymax;

    function automatic fixed_point_t clamp(input fixed_point_t v, input fixed_point_t hi);
        return (v < 0) ? '0 : ((v > hi) ? hi : v);
    endfunction

    // Pixel centres inside the vertex extent; a box wholly off one screen edge
    // would clamp onto that edge, so it is flagged empty before clamping.
    always_comb begin
        raw_xmin = fp_ceil(min3(x1, x2, x3));
        raw_xmax = fp_floor(max3(x1, x2, x3));
        raw_ymin = fp_ceil(min3(y1, y2, y3));
        raw_ymax = fp_floor(max3(y1, y2, y3));
        xmin     = clamp(raw_xmin, X_LAST);
        xmax     = clamp(raw_xmax, X_LAST);
        ymin     = clamp(raw_ymin, Y_LAST);
        ymax     = clamp(raw_ymax, Y_LAST);
        empty    = (raw_xmin > raw_xmax) || (raw_ymin > raw_ymax) ||
                   (raw_xmin > X_LAST)   || (raw_xmax < 0) ||
                   (raw_ymin > Y_LAST)   || (raw_ymax < 0);
    end

endmodule

// File: rtl/triangle_scan_controller.sv
// rtl/triangle_scan_controller.sv - bounding-box raster walk feeding a one-entry pixel output register
module triangle_scan_controller
    import triangle_scan_controller_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    triangle_scan_controller_if.slave    bus
);

    scan_state_t  state, state_next;
    vector4_t     v1_q, v2_q, v3_q, c1_q, c2_q, c3_q;
    fixed_point_t xmin_q, xmax_q, ymax_q, x_q, y_q;
    fixed_point_t bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic         bb_empty;
    logic         done_q;
    logic         pix_valid_q;
    fixed_point_t pix_x_q, pix_y_q;
    vector4_t     pix_colour_q;
    logic         capture, advance, drain_ok, row_end, last_pixel;

    triangle_bounding_box #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_bbox (
        .x1    (v1_q.x),
        .y1    (v1_q.y),
        .x2    (v2_q.x),
        .y2    (v2_q.y),
        .x3    (v3_q.x),
        .y3    (v3_q.y),
        .xmin  (bb_xmin),
        .xmax  (bb_xmax),
        .ymin  (bb_ymin),
        .ymax  (bb_ymax),
        .empty (bb_empty)
    );

    // Next state plus the per-cycle scan handshake decisions.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        advance    = 1'b0;
        drain_ok   = 1'b0;
        row_end    = (x_q == xmax_q);
        last_pixel = row_end && (y_q == ymax_q);
        case (state)
            ST_IDLE: begin
                if (bus.i_start) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                state_next = bb_empty ? ST_DRAIN : ST_SCAN;
            end
            ST_SCAN: begin
                // Uncovered pixels always move on; covered ones wait for room.
                capture = bus.i_raster_write && (!pix_valid_q || bus.i_pixel_ready);
                advance = !bus.i_raster_write || capture;
                if (advance && last_pixel) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_ok = !pix_valid_q || bus.i_pixel_ready;
                if (drain_ok) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Triangle latch, bounding box and scan position.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            v1_q   <= '0;
            v2_q   <= '0;
            v3_q   <= '0;
            c1_q   <= '0;
            c2_q   <= '0;
            c3_q   <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= drain_ok;
            if (state == ST_IDLE && bus.i_start) begin
                v1_q <= bus.i_v1;
                v2_q <= bus.i_v2;
                v3_q <= bus.i_v3;
                c1_q <= bus.i_c1;
                c2_q <= bus.i_c2;
                c3_q <= bus.i_c3;
            end
            if (state == ST_SETUP) begin
                xmin_q <= bb_xmin;
                xmax_q <= bb_xmax;
                ymax_q <= bb_ymax;
                if (!bb_empty) begin
                    x_q <= bb_xmin;
                    y_q <= bb_ymin;
                end
            end
            // The final pixel leaves the position parked at (xmax, ymax).
            if (advance && !last_pixel) begin
                if (row_end) begin
                    x_q <= xmin_q;
                    y_q <= y_q + 1;
                end else begin
                    x_q <= x_q + 1;
                end
            end
        end
    end

    // One-entry output register; a capture during a handshake refills it in place.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_colour_q <= '0;
        end else if (capture) begin
            pix_valid_q  <= 1'b1;
            pix_x_q      <= x_q;
            pix_y_q      <= y_q;
            pix_colour_q <= bus.i_raster_colour;
        end else if (pix_valid_q && bus.i_pixel_ready) begin
            pix_valid_q  <= 1'b0;
        end
    end

    assign bus.o_busy         = (state != ST_IDLE);
    assign bus.o_done         = done_q;
    assign bus.o_v1           = v1_q;
    assign bus.o_v2           = v2_q;
    assign bus.o_v3           = v3_q;
    assign bus.o_c1           = c1_q;
    assign bus.o_c2           = c2_q;
    assign bus.o_c3           = c3_q;
    assign bus.o_x            = x_q;
    assign bus.o_y            = y_q;
    assign bus.o_pixel_valid  = pix_valid_q;
    assign bus.o_pixel_x      = pix_x_q;
    assign bus.o_pixel_y      = pix_y_q;
    assign bus.o_pixel_colour = pix_colour_q;

endmodule

// File: doc/triangle_scan_controller.md
# triangle_scan_controller

Upstream driver and downstream collector for the triangle rasterizer stage.
- Latches one screen-space triangle and its vertex colours, then computes the clamped integer bounding box.
- Walks every pixel of that box in raster order, presenting each coordinate and the latched triangle to the combinational rasterizer.
- Forwards covered pixels through a one-entry valid/ready output register to the framebuffer writer.

## Interface
Parameters:
- SCREEN_WIDTH, 640, pixel columns; x clamp range is 0..SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 480, pixel rows; y clamp range is 0..SCREEN_HEIGHT-1.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_v1, i_v2, i_v3  in  Vector4_t each  screen-space vertices, fixed-point; only .x/.y used.
- i_c1, i_c2, i_c3  in  Vector4_t each  vertex RGBA colours.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when a triangle completes.
- o_v1, o_v2, o_v3, o_c1, o_c2, o_c3  out  Vector4_t each  latched triangle, wired to the rasterizer.
- o_x, o_y  out  32 signed  integer pixel coordinate, wired to the rasterizer.
- i_raster_write  in  1  rasterizer coverage for (o_x, o_y), same cycle.
- i_raster_colour  in  Vector4_t  rasterizer colour for (o_x, o_y), same cycle.
- o_pixel_valid  out  1  output register holds a pixel.
- i_pixel_ready  in  1  downstream accepts the pixel.
- o_pixel_x, o_pixel_y  out  32 signed  pixel coordinate.
- o_pixel_colour  out  Vector4_t  pixel colour.

## Operation
FixedPoint_t is 32-bit signed Q16.16.

States: IDLE, SETUP, SCAN, DRAIN.
- IDLE: when i_start=1, latch all six Vector4_t inputs and go to SETUP. Otherwise stay.
- SETUP (1 cycle): register the bounding box.
  - xmin = ceil(min(v.x)) = (min + 0xFFFF) >>> 16.
  - xmax = floor(max(v.x)) = max >>> 16.
  - y is computed the same way.
  - Clamp all four bounds to the screen.
  - If xmin>xmax or ymin>ymax, go to DRAIN (empty triangle). Otherwise set o_x=xmin, o_y=ymin and go to SCAN.
- SCAN: one candidate pixel per cycle.
  - capture = i_raster_write && (!o_pixel_valid || i_pixel_ready).
  - advance = !i_raster_write || capture.
  - On capture, load o_pixel_x/y = o_x/o_y and o_pixel_colour = i_raster_colour, and set valid.
  - On advance: x++. At xmax, x=xmin and y++. Advancing from (xmax, ymax) goes to DRAIN.
  - Uncovered pixels never stall.
- DRAIN: wait until o_pixel_valid=0 (or is handshaken this cycle). The next cycle pulses o_done and returns to IDLE.

Output register:
- valid clears on valid&&ready with no simultaneous capture.
- A simultaneous handshake and capture replaces the contents, and valid stays 1.
- Pixels are never dropped or duplicated.

Boundaries:
- i_start is ignored while busy; latched inputs do not change mid-triangle.
- Vertex inputs may change freely after the start cycle.
- Negative or off-screen vertices are clamped. A fully off-screen triangle produces zero pixels and still pulses o_done.

## Timing
- Reset clears all outputs and state asynchronously:
  - state = IDLE.
  - o_busy, o_done, o_pixel_valid = 0.
  - Coordinates, colours and latched vertices = 0.
- Reset asserted mid-scan abandons the triangle; the next i_start works normally.
- The start cycle is t0, SETUP is t1, and the first candidate pixel is presented at t2.
- Pixel latency: capture at cycle t means o_pixel_valid is high at t+1.
- Throughput is one candidate pixel per cycle when unstalled.
- An empty triangle pulses o_done at t3.

## Structure
- Add FP_FRAC_BITS=16 and the ceil/floor helper functions to FixedPoint.vh.
- Vector4_t stays in Vector4.vh.
- Sub-module triangle_bounding_box: combinational min/max/ceil/floor/clamp, parameterised by screen size. Its output is registered in SETUP.

## Test plan
The bench rasterizer model is "always write" unless stated otherwise.
- Basic scan: vertices (1.5,2.0), (4.25,2.0), (1.5,3.75), ready=1.
  - Candidate pixels in order: (2,2), (3,2), (4,2), (2,3), (3,3), (4,3), at t2..t7.
  - Six output handshakes at t3..t8, o_done at t9, busy t1..t8.
- Backpressure: same triangle, i_pixel_ready=0 during t4..t8.
  - o_x/o_y hold and o_pixel_* stay stable while stalled.
  - All six pixels arrive exactly once, in order.
- Clamp: vertices (-10,-10), (700,-10), (-10,500) -> x range 0..639, y range 0..479.
  - First candidate (0,0), last candidate (639,479).
- Empty triangle: vertices (1.2,1.2), (1.8,1.2), (1.2,1.8), or any fully off-screen triangle.
  - No pixel valid; o_done at t3.
- Sparse coverage: model writes only on even x.
  - Only even-x pixels are output, and the scan never stalls.
- Control: i_start during SCAN is ignored. Reset asserted mid-SCAN zeroes all outputs immediately; a subsequent start completes correctly.
